// File: rtl/flopenr.sv
// Resettable, enabled register: synchronous active-high reset to RESET_VAL,
// otherwise loads d when enable is high and holds when it is low.
module flopenr #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  // Reset has priority over enable; enable selects load versus hold.
  always_comb begin
    out_d = out_q;
    if (reset) begin
      out_d = RESET_VAL;
    end else if (enable) begin
      out_d = d;
    end
  end

  always_ff @(posedge clk) begin
    out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_flopenr.sv
// Directed bench for flopenr: a 1-bit instance driven from a vector table,
// plus an 8-bit instance with a non-zero reset value for mid-cycle corner cases.
module tb_flopenr;

  logic       clk;
  logic       rst1, en1, d1, out1;
  logic       rst8, en8;
  logic [7:0] d8, out8;

  int checks;
  int failures;

  typedef struct {
    logic  rst;
    logic  en;
    logic  d;
    logic  exp;
    string name;
  } vec1_t;

  vec1_t vecs[9];

  flopenr #(.WIDTH(1), .RESET_VAL(1'b0)) u_w1 (
    .clk(clk), .reset(rst1), .enable(en1), .d(d1), .out(out1)
  );

  flopenr #(.WIDTH(8), .RESET_VAL(8'hA5)) u_w8 (
    .clk(clk), .reset(rst8), .enable(en8), .d(d8), .out(out8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: out=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: out=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst1 = 1'b0; en1 = 1'b0; d1 = 1'b0;
    rst8 = 1'b0; en8 = 1'b0; d8 = 8'h00;

    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, "rst_beats_en"};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, "load_0"};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, "load_1"};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, "hold_d0_a"};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, "hold_d1"};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, "hold_d0_b"};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, "rst_without_en"};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, "rst_held"};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b1, "first_load_after_rst"};

    // Table-driven 1-bit sequence: drive on negedge, sample 1 after posedge.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rst1 = vecs[i].rst;
      en1  = vecs[i].en;
      d1   = vecs[i].d;
      @(posedge clk);
      #1;
      check1(vecs[i].name, out1, vecs[i].exp);
    end

    // Reset pulse entirely between edges, enable low: out must stay 1.
    @(negedge clk);
    en1 = 1'b0; d1 = 1'b0;
    #1 rst1 = 1'b1;
    #2 rst1 = 1'b0;
    check1("glitch_rst_mid_cycle", out1, 1'b1);
    @(posedge clk);
    #1;
    check1("glitch_rst_not_seen", out1, 1'b1);

    // Enabled d change between edges must not reach out before the edge.
    @(negedge clk);
    en1 = 1'b1; d1 = 1'b0;
    #2;
    check1("no_comb_path_d", out1, 1'b1);
    @(posedge clk);
    #1;
    check1("load_after_mid_change", out1, 1'b0);

    // 8-bit instance with RESET_VAL=A5.
    @(negedge clk);
    rst8 = 1'b1; en8 = 1'b1; d8 = 8'h3C;
    @(posedge clk);
    #1;
    check8("w8_reset_val", out8, 8'hA5);

    @(negedge clk);
    rst8 = 1'b0; en8 = 1'b1; d8 = 8'h3C;
    @(posedge clk);
    #1;
    check8("w8_load_3c", out8, 8'h3C);

    @(negedge clk);
    d8 = 8'hFF;
    #2;
    check8("w8_mid_cycle_d", out8, 8'h3C);
    d8 = 8'h5A;
    @(posedge clk);
    #1;
    check8("w8_load_5a", out8, 8'h5A);

    @(negedge clk);
    en8 = 1'b0; d8 = 8'h00;
    @(posedge clk);
    #1;
    check8("w8_hold", out8, 8'h5A);

    @(negedge clk);
    rst8 = 1'b1; en8 = 1'b0;
    @(posedge clk);
    #1;
    check8("w8_reset_no_en", out8, 8'hA5);

    @(negedge clk);
    rst8 = 1'b0; en8 = 1'b1; d8 = 8'h81;
    @(posedge clk);
    #1;
    check8("w8_first_load_after_rst", out8, 8'h81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
